sccb_write_master: RTL and testbench

Bit-level SCCB (I2C-compatible) 3-phase write engine for the OV7670. It sits directly downstream of the register-sequencing FSM. That FSM hands over one {reg_addr, reg_data} pair per transaction. This block generates START, the device address, the register address, the data byte, per-byte ACK sampling and STOP on an open-drain SCL/SDA pair, then reports done plus any NACK. Top level converts the oe outputs into the tri-state pads: pad = oe ? 0 : 'z.

---
 rtl/sccb_write_master_if.sv | 23 ++
 rtl/sccb_write_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_sccb_write_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_write_master_if.sv
// Request/status and open-drain bus bundle between the register sequencer and
// the SCCB write engine; slave is the engine side.
interface sccb_write_master_if;
  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       sda_in;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    output start, reg_addr, reg_data, sda_in,
    input  busy, done, ack_err, scl_oe, sda_oe
  );

  modport slave (
    input  start, reg_addr, reg_data, sda_in,
    output busy, done, ack_err, scl_oe, sda_oe
  );
endinterface

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write engine: START, DEV_ADDR, reg_addr, reg_data (each with ACK
// slot), STOP, on open-drain enables. Every phase is four quarter-SCL periods.
module sccb_write_master #(
  parameter int         QTR_CYCLES = 60,
  parameter logic [7:0] DEV_ADDR   = 8'h42
) (
  input logic               i_xclk,
  input logic               i_reset,
  sccb_write_master_if.slave bus
);

  localparam int            CW      = (QTR_CYCLES > 2) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(QTR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [1:0]    r_qtr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_byte_idx;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_ack_err;
  logic          r_busy;
  logic          r_done;
  logic          r_scl_oe;
  logic          r_sda_oe;

  state_t        w_state_nxt;
  logic [1:0]    w_qtr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_byte_nxt;
  logic [2:0]    w_bit_nxt;
  logic          w_ack_err_nxt;
  logic          w_accept;
  logic          w_tick;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_scl_nxt;
  logic          w_sda_nxt;
  logic [7:0]    w_tx_byte;
  logic          w_tx_bit;

  assign w_tick = (r_cnt == CNT_MAX);

  // State register; bus outputs are registered from the next-state decode.
  always_ff @(posedge i_xclk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_qtr      <= 2'd0;
      r_cnt      <= '0;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd7;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_ack_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_qtr      <= w_qtr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_byte_idx <= w_byte_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_ack_err  <= w_ack_err_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_scl_oe   <= w_scl_nxt;
      r_sda_oe   <= w_sda_nxt;
      if (w_accept) begin
        r_addr <= bus.reg_addr;
        r_data <= bus.reg_data;
      end else begin
        r_addr <= r_addr;
        r_data <= r_data;
      end
    end
  end

  // Next-state: the 2-bit quarter index wraps 3->0 on its own at phase ends.
  always_comb begin
    w_state_nxt   = r_state;
    w_qtr_nxt     = r_qtr;
    w_byte_nxt    = r_byte_idx;
    w_bit_nxt     = r_bit_idx;
    w_ack_err_nxt = r_ack_err;
    w_accept      = 1'b0;
    w_cnt_nxt     = '0;

    if ((r_state == S_IDLE) || (r_state == S_DONE) || w_tick) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept      = 1'b1;
          w_state_nxt   = S_START;
          w_qtr_nxt     = 2'd0;
          w_byte_nxt    = 2'd0;
          w_bit_nxt     = 3'd7;
          w_ack_err_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            w_state_nxt = S_BIT;
          end else begin
            w_state_nxt = S_START;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_BIT: begin
        if (w_tick && (r_qtr == 2'd3)) begin
          w_qtr_nxt = 2'd0;
          if (r_bit_idx == 3'd0) begin
            w_state_nxt = S_ACK;
          end else begin
            w_bit_nxt = r_bit_idx - 3'd1;
          end
        end else if (w_tick) begin
          w_qtr_nxt = r_qtr + 2'd1;
        end else begin
          w_state_nxt = S_BIT;
        end
      end
      S_ACK: begin
        // A set ack_err here can only come from this byte's slot: earlier NACKs aborted.
        if (w_tick && (r_qtr == 2'd2)) begin
          w_qtr_nxt = 2'd3;
          if (bus.sda_in) begin
            w_ack_err_nxt = 1'b1;
          end else begin
            w_ack_err_nxt = r_ack_err;
          end
        end else if (w_tick && (r_qtr == 2'd3)) begin
          w_qtr_nxt = 2'd0;
          if (r_ack_err || (r_byte_idx == 2'd2)) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_BIT;
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_bit_nxt   = 3'd7;
          end
        end else if (w_tick) begin
          w_qtr_nxt = r_qtr + 2'd1;
        end else begin
          w_state_nxt = S_ACK;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_qtr_nxt   = 2'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_qtr_nxt   = 2'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins change with the state itself.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_scl_nxt  = 1'b0;
    w_sda_nxt  = 1'b0;

    case (w_byte_nxt)
      2'd0:    w_tx_byte = DEV_ADDR;
      2'd1:    w_tx_byte = r_addr;
      default: w_tx_byte = r_data;
    endcase
    w_tx_bit = w_tx_byte[w_bit_nxt];

    case (w_state_nxt)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      S_START: begin
        w_busy_nxt = 1'b1;
        w_sda_nxt  = (w_qtr_nxt != 2'd0);
      end
      S_BIT: begin
        w_busy_nxt = 1'b1;
        w_scl_nxt  = ~w_qtr_nxt[1];
        w_sda_nxt  = ~w_tx_bit;
      end
      S_ACK: begin
        w_busy_nxt = 1'b1;
        w_scl_nxt  = ~w_qtr_nxt[1];
      end
      S_STOP: begin
        w_busy_nxt = 1'b1;
        w_scl_nxt  = (w_qtr_nxt == 2'd0);
        w_sda_nxt  = ~w_qtr_nxt[1];
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;
  assign bus.scl_oe  = r_scl_oe;
  assign bus.sda_oe  = r_sda_oe;

endmodule

// File: tb/tb_sccb_write_master.sv
// Bench: two engines (QTR_CYCLES 4 and 2) checked every cycle against a
// timeline model of the write, plus directed latency/bus-decode checks.
module tb_sccb_write_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic [7:0] ra    [2];
  logic [7:0] rd    [2];
  int         nack_byte [2];

  wire        busy_w [2];
  wire        done_w [2];
  wire        err_w  [2];
  wire        scl_w  [2];
  wire        sda_w  [2];
  wire [4:0]  exp_w  [2];
  wire [31:0] rise_w [2];
  wire [31:0] bits_w [2];
  wire [31:0] nst_w  [2];
  wire [31:0] nsp_w  [2];
  wire [31:0] stat_w [2];
  wire [31:0] spat_w [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Quarters in a write: START + 9 quarters-of-4 per byte sent + STOP.
  function automatic int len_of(int nack);
    return (nack >= 0 && nack <= 2) ? 8 + (nack + 1) * 36 : 116;
  endfunction

  // {busy, done, scl_oe, sda_oe} for cycle t after accept (t=0: idle).
  function automatic logic [3:0] exp_out(int t, int q, logic [7:0] a, logic [7:0] d, int nack);
    int len, n, p, qq, slot;
    logic [7:0] b;
    len = len_of(nack);
    if (t == 0) return 4'b0000;
    if (t == len * q + 1) return 4'b0100;
    n = (t - 1) / q;
    p = n / 4;
    qq = n % 4;
    if (p == 0) return {2'b10, 1'b0, (qq != 0)};
    if (n >= len - 4) return {2'b10, (qq == 0), (qq < 2)};
    slot = (p - 1) % 9;
    b = ((p - 1) / 9 == 0) ? 8'h42 : (((p - 1) / 9 == 1) ? a : d);
    if (slot == 8) return {2'b10, (qq < 2), 1'b0};
    return {2'b10, (qq < 2), ~b[7 - slot]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int Q = (g == 0) ? 4 : 2;
    sccb_write_master_if bus ();

    int         t = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_d = 8'h00;
    int         m_nack = 7;
    logic       hold = 1'b0;
    int         rise = 0;
    logic [31:0] bits = 32'h0;
    int         nst = 0, nsp = 0, stat = 0, spat = 0;
    logic       pscl = 1'b0, psda = 1'b0;

    assign bus.start    = start[g];
    assign bus.reg_addr = ra[g];
    assign bus.reg_data = rd[g];
    assign bus.sda_in   = (rise == 9 * nack_byte[g] + 9);

    sccb_write_master #(.QTR_CYCLES(Q), .DEV_ADDR(8'h42)) dut (
      .i_xclk (clk),
      .i_reset(rst[g]),
      .bus    (bus)
    );

    always @(posedge clk) begin
      if (rst[g]) begin
        t    <= 0;
        hold <= 1'b0;
      end else if (t == 0) begin
        if (start[g]) begin
          t      <= 1;
          m_a    <= ra[g];
          m_d    <= rd[g];
          m_nack <= nack_byte[g];
        end
      end else if (t == len_of(m_nack) * Q + 1) begin
        t    <= 0;
        hold <= (m_nack >= 0 && m_nack <= 2);
      end else begin
        t <= t + 1;
      end
    end

    wire e_exp = (t == 0) ? hold : ((m_nack >= 0) && (m_nack <= 2) && (t > (36 * m_nack + 39) * Q));
    assign exp_w[g] = {exp_out(t, Q, m_a, m_d, m_nack), e_exp};

    always @(negedge clk) begin
      if (t == 1) begin
        rise <= 0; bits <= 32'h0; nst <= 0; nsp <= 0; stat <= 0; spat <= 0;
      end else begin
        if (pscl && !bus.scl_oe) begin
          rise <= rise + 1;
          bits <= {bits[30:0], ~bus.sda_oe};
        end
        if (!pscl && !bus.scl_oe && (psda != bus.sda_oe)) begin
          if (bus.sda_oe) begin nst <= nst + 1; stat <= rise; end
          else begin nsp <= nsp + 1; spat <= rise; end
        end
      end
      pscl <= bus.scl_oe;
      psda <= bus.sda_oe;
    end

    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign err_w[g]  = bus.ack_err;
    assign scl_w[g]  = bus.scl_oe;
    assign sda_w[g]  = bus.sda_oe;
    assign rise_w[g] = rise;
    assign bits_w[g] = bits;
    assign nst_w[g]  = nst;
    assign nsp_w[g]  = nsp;
    assign stat_w[g] = stat;
    assign spat_w[g] = spat;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({busy_w[i], done_w[i], scl_w[i], sda_w[i], err_w[i]} !== exp_w[i]) begin
          n_err++;
          $display("FAIL model[%0d] @%0t: busy/done/scl/sda/err got %b expected %b", i, $time,
                   {busy_w[i], done_w[i], scl_w[i], sda_w[i], err_w[i]}, exp_w[i]);
        end
      end
    end
  endtask

  task automatic wait_busy(int i, string name);
    int c = 0;
    while (!busy_w[i] && c < 20) begin step(); c++; end
    check({name, "_accept"}, {31'd0, busy_w[i]}, 32'd1);
  endtask

  task automatic measure(int i, output int lat);
    lat = 0;
    do begin step(); lat++; end while (!done_w[i] && lat < 3000);
  endtask

  task automatic bus_checks(int i, string name, logic exp_e, logic [31:0] exp_bits, int exp_rise);
    check({name, "_ack_err"}, {31'd0, err_w[i]}, {31'd0, exp_e});
    check({name, "_sda_bits"}, bits_w[i], exp_bits);
    check({name, "_scl_rises"}, rise_w[i], exp_rise);
    check({name, "_n_start"}, nst_w[i], 32'd1);
    check({name, "_n_stop"}, nsp_w[i], 32'd1);
    check({name, "_start_pos"}, stat_w[i], 32'd0);
    check({name, "_stop_pos"}, spat_w[i], exp_rise);
  endtask

  task automatic run_txn(int i, logic [7:0] a, logic [7:0] d, int nk, string name,
                         int exp_lat, logic exp_e, logic [31:0] exp_bits, int exp_rise);
    int lat;
    ra[i] = a; rd[i] = d; nack_byte[i] = nk; start[i] = 1'b1;
    wait_busy(i, name);
    start[i] = 1'b0;
    measure(i, lat);
    check({name, "_latency"}, lat, exp_lat);
    bus_checks(i, name, exp_e, exp_bits, exp_rise);
    step();
    check({name, "_err_held"}, {30'd0, busy_w[i], err_w[i]}, {30'd0, 1'b0, exp_e});
  endtask

  logic [31:0] full_bits;

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; ra[i] = 8'h00; rd[i] = 8'h00; nack_byte[i] = 7;
    end
    step();
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++)
      check("reset_outputs", {27'd0, busy_w[i], done_w[i], scl_w[i], sda_w[i], err_w[i]}, 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    full_bits = {4'd0, 8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1, 1'b0};
    run_txn(0, 8'h12, 8'h80, 7, "full_q4", 464, 1'b0, full_bits, 28);
    run_txn(0, 8'h12, 8'h80, 1, "nack_b1", 320, 1'b1, {13'd0, 8'h42, 1'b1, 8'h12, 1'b1, 1'b0}, 19);

    // start held through a transaction with new operands, then back-to-back
    ra[0] = 8'h12; rd[0] = 8'h80; nack_byte[0] = 7; start[0] = 1'b1;
    wait_busy(0, "b2b_first");
    ra[0] = 8'hFF; rd[0] = 8'h33;
    measure(0, lat);
    check("b2b_first_latency", lat, 464);
    bus_checks(0, "b2b_first", 1'b0, full_bits, 28);
    step();
    check("b2b_idle_gap", {31'd0, busy_w[0]}, 32'd0);
    step();
    check("b2b_second_accept", {31'd0, busy_w[0]}, 32'd1);
    start[0] = 1'b0;
    measure(0, lat);
    check("b2b_second_latency", lat, 464);
    bus_checks(0, "b2b_second", 1'b0, {4'd0, 8'h42, 1'b1, 8'hFF, 1'b1, 8'h33, 1'b1, 1'b0}, 28);
    step();

    // reset pulse during quarter q1 of byte 1
    ra[0] = 8'h12; rd[0] = 8'h80; start[0] = 1'b1;
    wait_busy(0, "abort");
    start[0] = 1'b0;
    repeat (165) step();
    check("abort_pre_reset_scl", {31'd0, scl_w[0]}, 32'd1);
    rst[0] = 1'b1;
    step();
    check("abort_reset_outputs", {27'd0, busy_w[0], done_w[0], scl_w[0], sda_w[0], err_w[0]}, 32'd0);
    rst[0] = 1'b0;
    step();
    run_txn(0, 8'h12, 8'h80, 7, "after_reset", 464, 1'b0, full_bits, 28);

    run_txn(1, 8'h12, 8'h80, 7, "full_q2", 232, 1'b0, full_bits, 28);
    run_txn(1, 8'h5A, 8'hC3, 0, "nack_b0_q2", 88, 1'b1, {22'd0, 8'h42, 1'b1, 1'b0}, 10);
    run_txn(1, 8'h12, 8'h80, 2, "nack_b2_q2", 232, 1'b1, full_bits, 28);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
